serdes_tx_sched: RTL and testbench
==================================

# serdes_tx_sched

Transmit-side scheduler for the serial link. It arbitrates round-robin between NUM_REQ byte-stream requesters and frames the granted stream as SYNC byte, header byte, then payload bytes. It serializes the frame LSB-first, one bit per clock, onto the single-bit line that feeds the SERDES receive path (bit 0 of the input bus).

## Interface

Parameters:
- NUM_REQ, 4: number of requesters, 1..16
- SYNC_BYTE, 8'hD5: frame sync byte
- MAX_BURST, 8: max payload bytes per frame, 1..255
- GAP_CYCLES, 2: idle bit-times between frames, 0..15

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  arbitration enable; a frame in progress always completes
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is the last of the packet
- req_ready  out  NUM_REQ  one-cycle byte-accept strobe; combinational
- ser_out  out  1  serial bit, registered
- ser_frame  out  1  high for every bit of a frame, registered
- ser_sof  out  1  high during bit 0 of SYNC, registered
- busy  out  1  state is not IDLE
- grant_id  out  4  current or last granted requester
- err_underrun  out  1  one-cycle pulse on payload underrun

## Operation

- Protocol rule: once a requester raises req_valid, it holds req_valid, req_data and req_last stable until it sees req_ready.
- States and transitions:
  - IDLE → SYNC when en=1 and any req_valid is high. The grant is latched at that edge.
  - SYNC → HDR → DATA.
  - DATA → CHK (only with the macro) or GAP when a frame-end condition occurs.
  - GAP → IDLE after GAP_CYCLES cycles. If GAP_CYCLES=0, the block returns to IDLE directly.
- Each byte occupies exactly 8 cycles. bit_cnt runs 0..7, and bit k of the byte drives ser_out at bit_cnt=k.
- Header byte is {4'hA, id[3:0]}.
- Payload loading: at bit_cnt=7 of HDR or of a DATA byte, req_ready[grant] is asserted in that cycle if req_valid[grant]=1. The byte is captured at that edge.
- Frame-end conditions at a byte boundary (checked in priority order, after the byte in flight finishes):
  - the previous byte had req_last=1;
  - the payload count reached MAX_BURST (the requester is re-arbitrated later and continues with no last seen);
  - req_valid[grant]=0. This is an underrun: err_underrun pulses in that cycle.
- Round-robin: the search starts at (last grant + 1) mod NUM_REQ. After reset the pointer is 0, so requester 0 has highest priority. The pointer updates at the grant.
- Outside frames: ser_out=0 and ser_frame=0.

## Timing

- Reset: every output is 0, state IDLE, RR pointer 0, and grant_id=0. This takes effect immediately, mid-frame included. Any partially sent byte is discarded, and an already-accepted byte is lost.
- Arbitration happens in cycle t. SYNC bit 0 and ser_sof appear at t+1. HDR occupies t+9..t+16. The first req_ready is at t+16, and payload bit 0 is at t+17.
- The next payload byte's req_ready comes 8 cycles after the previous one. No back-to-back bubbles occur within a frame.
- A frame with n payload bytes holds ser_frame high for 8(n+2) cycles, or 8(n+3) cycles with the checksum.
- No arbitration takes place during GAP. The earliest next SYNC bit 0 is GAP_CYCLES+2 cycles after the last frame bit.

## Configuration

- SERDES_TX_SCHED_CHK_EN defined: after the last payload byte, one CHK byte is sent. CHK is the XOR of all payload bytes of the frame (SYNC and HDR are excluded). ser_frame stays high through CHK.
- Macro undefined: no CHK state, no XOR register, and the frame ends after the last payload bit.

## Structure

- Shared package serdes_pkg holds:
  - state enum (IDLE, SYNC, HDR, DATA, CHK, GAP);
  - HDR_TAG = 4'hA;
  - default SYNC_BYTE.
- One sub-module, serdes_rr_arb: NUM_REQ-wide round-robin arbiter with a pointer register. It outputs a one-hot grant and an encoded id.
- The FSM, bit counter, burst counter, shift register and checksum stay in serdes_tx_sched.

## Test plan

- **Single byte:** req0 sends 0xA5 with last=1. Expect ser_out = D5, A0, A5 (LSB-first) over 24 cycles, then 2 gap cycles at 0. With the macro, A5 follows as CHK and ser_frame lasts 32 cycles.
- **Round-robin:** req1 and req2 are both valid with one byte each. Expect frame HDR=A1, then frame HDR=A2. Both are then re-requested: expect HDR=A1 next (search starts at 3, wraps past 0).
- **Burst limit:** req0 sends bytes 0x00..0x09 with last on 0x09, MAX_BURST=8. Expect frame 1 with 8 payload bytes and no err_underrun, then frame 2 with bytes 0x08, 0x09.
- **Underrun:** req3 sends 0x11 with last=0, then drops valid. Expect the frame to end after 0x11 and err_underrun to pulse for 1 cycle at that byte's bit_cnt=7.
- **Reset mid-frame:** assert rst_n=0 during HDR. Expect all outputs 0 in the same cycle. After release, simultaneous requests from req0 and req2 produce grant 0.
- **Checksum (macro defined):** payload 0x3C, 0xA5, 0xFF, 0x12. Expect CHK byte 0x74.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared types and constants for the serial-link transmit scheduler.
// Used by serdes_rr_arb and serdes_tx_sched.
package serdes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_HDR  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_GAP  = 3'd5
  } state_e;

  localparam logic [3:0] HDR_TAG       = 4'hA;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hD5;

  function automatic logic [7:0] hdr_byte(input logic [3:0] id);
    return {HDR_TAG, id};
  endfunction

endpackage

// File: rtl/serdes_rr_arb.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves
// to one past the winner whenever advance_i accepts a grant.
module serdes_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [3:0]         id_o,
  output logic               any_o
);

  logic [3:0] ptr_q, ptr_d;

  // Two passes: first from the pointer upward, then from 0, which wraps the search.
  always_comb begin
    gnt_o = '0;
    id_o  = 4'd0;
    any_o = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!any_o && req_i[j] && (4'(j) >= ptr_q)) begin
        any_o    = 1'b1;
        id_o     = 4'(j);
        gnt_o[j] = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        id_o     = 4'(j);
        gnt_o[j] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && any_o) begin
      ptr_d = (id_o == 4'(NUM_REQ - 1)) ? 4'd0 : id_o + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 4'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/serdes_tx_sched.sv
// Transmit scheduler: round-robin grant, SYNC/HDR/payload framing, LSB-first serializer.
// Define SERDES_TX_SCHED_CHK_EN to append an XOR checksum byte after the payload.
module serdes_tx_sched
  import serdes_pkg::*;
#(
  parameter int         NUM_REQ    = 4,
  parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE,
  parameter int         MAX_BURST  = 8,
  parameter int         GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 ser_out,
  output logic                 ser_frame,
  output logic                 ser_sof,
  output logic                 busy,
  output logic [3:0]           grant_id,
  output logic                 err_underrun
);

  localparam logic [7:0] BURST_MAX   = 8'(MAX_BURST);
  localparam logic [3:0] GAP_LAST    = 4'(GAP_CYCLES - 1);
  localparam state_e     AFTER_FRAME = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  state_e               state_q, state_d;
  logic [2:0]           bit_cnt_q;
  logic [7:0]           sh_q;
  logic [7:0]           burst_q;
  logic                 last_q;
  logic [3:0]           gap_q;
  logic [3:0]           gid_q;
  logic [NUM_REQ-1:0]   goh_q;
  logic                 frame_q;
  logic                 sof_q;
`ifdef SERDES_TX_SCHED_CHK_EN
  logic [7:0]           chk_q;
`endif

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [3:0]           arb_id;
  logic                 arb_any;
  logic                 start;
  logic                 byte_end;
  logic                 load_slot;
  logic                 accept;
  logic                 underrun;
  logic                 sel_valid;
  logic                 sel_last;
  logic [7:0]           sel_data;

  assign start = (state_q == ST_IDLE) && en && arb_any;

  serdes_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req_valid),
    .advance_i (start),
    .gnt_o     (arb_gnt),
    .id_o      (arb_id),
    .any_o     (arb_any)
  );

  // Mux the granted requester's byte lane via the latched one-hot grant.
  always_comb begin
    sel_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (goh_q[i]) sel_data = sel_data | req_data[8*i +: 8];
    end
  end

  assign sel_valid = |(req_valid & goh_q);
  assign sel_last  = |(req_last & goh_q);
  assign byte_end  = (bit_cnt_q == 3'd7);

  // A fetch slot exists at the end of HDR or of a payload byte unless the
  // packet already ended or the burst is full; an empty slot is an underrun.
  assign load_slot = byte_end &&
                     ((state_q == ST_HDR) ||
                      ((state_q == ST_DATA) && !last_q && (burst_q != BURST_MAX)));
  assign accept    = load_slot && sel_valid;
  assign underrun  = load_slot && !sel_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SYNC;
      ST_SYNC: if (byte_end) state_d = ST_HDR;
      ST_HDR:  if (byte_end) state_d = accept ? ST_DATA : AFTER_FRAME;
      ST_DATA: begin
        if (byte_end && !accept) begin
`ifdef SERDES_TX_SCHED_CHK_EN
          state_d = ST_CHK;
`else
          state_d = AFTER_FRAME;
`endif
        end
      end
      ST_CHK:  if (byte_end) state_d = AFTER_FRAME;
      ST_GAP:  if (gap_q == GAP_LAST) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = accept ? (req_valid & goh_q) : '0;
    err_underrun = underrun;
    busy         = (state_q != ST_IDLE);
  end

  assign ser_out   = sh_q[0];
  assign ser_frame = frame_q;
  assign ser_sof   = sof_q;
  assign grant_id  = gid_q;

  // sh_q[0] is the line itself, so loading a byte at an edge puts its bit 0
  // on ser_out in the very next cycle; clearing it keeps the idle line at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= 3'd0;
      sh_q      <= 8'h00;
      burst_q   <= 8'd0;
      last_q    <= 1'b0;
      gap_q     <= 4'd0;
      gid_q     <= 4'd0;
      goh_q     <= '0;
      frame_q   <= 1'b0;
      sof_q     <= 1'b0;
`ifdef SERDES_TX_SCHED_CHK_EN
      chk_q     <= 8'h00;
`endif
    end else begin
      sof_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sh_q      <= SYNC_BYTE;
            frame_q   <= 1'b1;
            sof_q     <= 1'b1;
            bit_cnt_q <= 3'd0;
            burst_q   <= 8'd0;
            last_q    <= 1'b0;
            gid_q     <= arb_id;
            goh_q     <= arb_gnt;
`ifdef SERDES_TX_SCHED_CHK_EN
            chk_q     <= 8'h00;
`endif
          end
        end
        ST_SYNC, ST_HDR, ST_DATA, ST_CHK: begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (!byte_end) begin
            sh_q <= {1'b0, sh_q[7:1]};
          end else if (state_q == ST_SYNC) begin
            sh_q <= hdr_byte(gid_q);
          end else if (accept) begin
            sh_q    <= sel_data;
            burst_q <= burst_q + 8'd1;
            last_q  <= sel_last;
`ifdef SERDES_TX_SCHED_CHK_EN
            chk_q   <= chk_q ^ sel_data;
`endif
          end
`ifdef SERDES_TX_SCHED_CHK_EN
          else if (state_q == ST_DATA) begin
            sh_q <= chk_q;
          end
`endif
          else begin
            sh_q    <= 8'h00;
            frame_q <= 1'b0;
            gap_q   <= 4'd0;
          end
        end
        ST_GAP: gap_q <= gap_q + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_tx_sched.sv
// Directed bench for serdes_tx_sched: per-requester source queues, a line
// monitor that rebuilds frames, and an expected-byte queue compared per test.
module tb_serdes_tx_sched;

  localparam int NREQ = 4;
`ifdef SERDES_TX_SCHED_CHK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                en;
  logic [NREQ-1:0]     req_valid;
  logic [8*NREQ-1:0]   req_data;
  logic [NREQ-1:0]     req_last;
  logic [NREQ-1:0]     req_ready;
  logic                ser_out, ser_frame, ser_sof, busy, err_underrun;
  logic [3:0]          grant_id;

  serdes_tx_sched #(
    .NUM_REQ    (NREQ),
    .SYNC_BYTE  (8'hD5),
    .MAX_BURST  (8),
    .GAP_CYCLES (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .ser_out      (ser_out),
    .ser_frame    (ser_frame),
    .ser_sof      (ser_sof),
    .busy         (busy),
    .grant_id     (grant_id),
    .err_underrun (err_underrun)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // ---------------- scoreboard state ----------------
  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  int          flen_q[$], end_q[$], sof_q[$], rdy_q[$];
  int          frames = 0, ur_cnt = 0, ur_cyc = 0, out_bad = 0, sof_bad = 0;
  logic [7:0]  chk_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- source driver ----------------
  logic [8:0]      src_q[NREQ][$];
  logic [NREQ-1:0] pend;
  logic [8:0]      popped;

  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    pend      = '0;
    forever begin
      @(negedge clk);
      pend = pend | req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && src_q[i].size() > 0) popped = src_q[i].pop_front();
        pend[i] = 1'b0;
        if (src_q[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_last[i]        = src_q[i][0][8];
          req_data[8*i +: 8] = src_q[i][0][7:0];
        end else begin
          req_valid[i]       = 1'b0;
          req_last[i]        = 1'b0;
          req_data[8*i +: 8] = 8'h00;
        end
      end
    end
  end

  // ---------------- line monitor ----------------
  initial begin : monitor
    bit         in_frame;
    int         flen, bitpos, last_cyc;
    logic [7:0] cur;
    in_frame = 0; flen = 0; bitpos = 0; last_cyc = 0; cur = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 0; flen = 0; bitpos = 0;
      end else begin
        if (ser_sof) sof_q.push_back(cyc);
        if (|req_ready) rdy_q.push_back(cyc);
        if (err_underrun) begin ur_cnt++; ur_cyc = cyc; end
        if (ser_frame) begin
          if (ser_sof !== !in_frame) sof_bad++;
          in_frame = 1;
          cur[bitpos] = ser_out;
          bitpos++;
          flen++;
          last_cyc = cyc;
          if (bitpos == 8) begin obs_q.push_back(cur); bitpos = 0; end
        end else begin
          if (ser_out !== 1'b0 || ser_sof !== 1'b0) out_bad++;
          if (in_frame) begin
            in_frame = 0;
            flen_q.push_back(flen);
            end_q.push_back(last_cyc);
            frames++;
            flen = 0; bitpos = 0;
          end
        end
      end
    end
  end

  // ---------------- expectation helpers ----------------
  task automatic exp_hdr(input logic [3:0] id);
    exp_q.push_back(8'hD5);
    exp_q.push_back({4'hA, id});
    chk_acc = 8'h00;
  endtask

  task automatic exp_pl(input logic [7:0] b);
    exp_q.push_back(b);
    chk_acc = chk_acc ^ b;
  endtask

  task automatic exp_end();
    if (CHK != 0) exp_q.push_back(chk_acc);
  endtask

  task automatic cmp_bytes(input string tag, input int ob);
    check({tag, "_nbytes"}, obs_q.size() - ob, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (ob + k < obs_q.size()) check($sformatf("%s_b%0d", tag, k), obs_q[ob + k], exp_q[k]);
    end
    exp_q.delete();
  endtask

  task automatic wait_frames(input string tag, input int n);
    int budget;
    budget = 0;
    while (!(frames >= n && !busy) && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    check({tag, "_done"}, (frames >= n && !busy) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // ---------------- directed tests ----------------
  int fb, ob, sb, rb, ub, budget;

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ser_out", ser_out, 0);
    check("rst_frame", ser_frame, 0);
    check("rst_sof", ser_sof, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_ready", req_ready, 0);
    check("rst_underrun", err_underrun, 0);
    rst_n = 1'b1;

    // Single byte from req0
    fb = frames; ob = obs_q.size(); sb = sof_q.size(); rb = rdy_q.size();
    src_q[0].push_back({1'b1, 8'hA5});
    exp_hdr(4'd0); exp_pl(8'hA5); exp_end();
    wait_frames("single", fb + 1);
    cmp_bytes("single", ob);
    check("single_len", flen_q[fb], 8 * (1 + 2 + CHK));
    check("single_ready_lat", rdy_q[rb] - sof_q[sb], 15);
    check("single_gid", grant_id, 0);

    // Round-robin between req1 and req2, then re-request both
    fb = frames; ob = obs_q.size(); sb = sof_q.size();
    src_q[1].push_back({1'b1, 8'hB1});
    src_q[2].push_back({1'b1, 8'hB2});
    wait_frames("rr_a", fb + 2);
    check("rr_gap", sof_q[sb + 1] - end_q[fb], 4);
    check("rr_gid_a", grant_id, 2);
    src_q[1].push_back({1'b1, 8'hB1});
    src_q[2].push_back({1'b1, 8'hB2});
    wait_frames("rr_b", fb + 4);
    exp_hdr(4'd1); exp_pl(8'hB1); exp_end();
    exp_hdr(4'd2); exp_pl(8'hB2); exp_end();
    exp_hdr(4'd1); exp_pl(8'hB1); exp_end();
    exp_hdr(4'd2); exp_pl(8'hB2); exp_end();
    cmp_bytes("rr", ob);

    // Burst limit: 10 bytes split 8 + 2
    fb = frames; ob = obs_q.size(); rb = rdy_q.size(); ub = ur_cnt;
    for (int b = 0; b < 10; b++) src_q[0].push_back({(b == 9) ? 1'b1 : 1'b0, 8'(b)});
    exp_hdr(4'd0);
    for (int b = 0; b < 8; b++) exp_pl(8'(b));
    exp_end();
    exp_hdr(4'd0); exp_pl(8'h08); exp_pl(8'h09); exp_end();
    wait_frames("burst", fb + 2);
    cmp_bytes("burst", ob);
    check("burst_len1", flen_q[fb], 8 * (8 + 2 + CHK));
    check("burst_len2", flen_q[fb + 1], 8 * (2 + 2 + CHK));
    check("burst_no_underrun", ur_cnt - ub, 0);
    check("burst_ready_gap_first", rdy_q[rb + 1] - rdy_q[rb], 8);
    check("burst_ready_gap_last", rdy_q[rb + 7] - rdy_q[rb + 6], 8);

    // Underrun: req3 sends one byte without last, then goes quiet
    fb = frames; ob = obs_q.size(); ub = ur_cnt;
    src_q[3].push_back({1'b0, 8'h11});
    exp_hdr(4'd3); exp_pl(8'h11); exp_end();
    wait_frames("underrun", fb + 1);
    cmp_bytes("underrun", ob);
    check("underrun_pulses", ur_cnt - ub, 1);
    check("underrun_cycle", ur_cyc, end_q[fb] - 8 * CHK);
    check("underrun_len", flen_q[fb], 8 * (1 + 2 + CHK));
    check("underrun_gid", grant_id, 3);

    // Arbitration enable held low
    fb = frames; ob = obs_q.size();
    en = 1'b0;
    src_q[1].push_back({1'b1, 8'hC3});
    repeat (20) @(negedge clk);
    check("en_low_busy", busy, 0);
    check("en_low_frames", frames - fb, 0);
    en = 1'b1;
    exp_hdr(4'd1); exp_pl(8'hC3); exp_end();
    wait_frames("en", fb + 1);
    cmp_bytes("en", ob);

    // Reset during HDR
    sb = sof_q.size();
    src_q[2].push_back({1'b1, 8'h77});
    budget = 0;
    while (sof_q.size() == sb && budget < 200) begin @(negedge clk); budget++; end
    check("rstmid_sof_seen", sof_q.size() - sb, 1);
    repeat (10) @(negedge clk);
    check("rstmid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_ser_out", ser_out, 0);
    check("rstmid_frame", ser_frame, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_gid", grant_id, 0);
    check("rstmid_ready", req_ready, 0);
    src_q[2].delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fb = frames; ob = obs_q.size();
    src_q[0].push_back({1'b1, 8'h5A});
    src_q[2].push_back({1'b1, 8'h6B});
    exp_hdr(4'd0); exp_pl(8'h5A); exp_end();
    exp_hdr(4'd2); exp_pl(8'h6B); exp_end();
    wait_frames("rstmid", fb + 2);
    cmp_bytes("rstmid", ob);

    // Four-byte payload; checksum 0x74 when enabled
    fb = frames; ob = obs_q.size();
    src_q[0].push_back({1'b0, 8'h3C});
    src_q[0].push_back({1'b0, 8'hA5});
    src_q[0].push_back({1'b0, 8'hFF});
    src_q[0].push_back({1'b1, 8'h12});
    exp_hdr(4'd0); exp_pl(8'h3C); exp_pl(8'hA5); exp_pl(8'hFF); exp_pl(8'h12); exp_end();
    wait_frames("chk", fb + 1);
    cmp_bytes("chk", ob);
    check("chk_len", flen_q[fb], 8 * (4 + 2 + CHK));
`ifdef SERDES_TX_SCHED_CHK_EN
    check("chk_byte", obs_q[ob + 6], 8'h74);
`endif

    check("idle_line_clean", out_bad, 0);
    check("sof_alignment", sof_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
